// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory port arbiter:
//   - RV32 load/store funct3 encodings
//   - arbiter FSM state type
//   - store opcodes decoded upstream of the arbiter
//   - f3_illegal(): flags funct3 codes that are not legal for the access type
// ----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [6:0] OPC_STORE   = 7'h23;
   localparam logic [6:0] OPC_PSRF_ST = 7'h24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Stores only accept B/H/W; loads additionally accept BU/HU.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      logic v_bad;
      case (f3)
         F3_B, F3_H, F3_W: v_bad = 1'b0;
         F3_BU, F3_HU:     v_bad = we;
         default:          v_bad = 1'b1;
      endcase
      return v_bad;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane helper shared by the store and load paths.
// Ports:
//   i_func3     access size/sign (RV32 funct3)
//   i_addr      byte offset inside the word
//   i_wdata     right-justified store data
//   i_rdata     raw word read from memory
//   o_we_mask   byte-lane write mask for a store of this size/offset
//   o_din       store data replicated across all lanes
//   o_rdata_ext selected byte/half, sign- or zero-extended; word passed through
//   o_misalign  half not on a 2-byte boundary or word not on a 4-byte boundary
// ----------------------------------------------------------------------------
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  i_func3,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_we_mask,
   output logic [31:0] o_din,
   output logic [31:0] o_rdata_ext,
   output logic        o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed byte and half out of the read word.
   always_comb begin
      w_byte = 8'd0;
      case (i_addr)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = 8'd0;
      endcase
      if (i_addr[1]) begin
         w_half = i_rdata[31:16];
      end else begin
         w_half = i_rdata[15:0];
      end
   end

   // Size-dependent mask, lane replication, load extension and alignment.
   always_comb begin
      o_we_mask   = 4'b0000;
      o_din       = 32'd0;
      o_rdata_ext = 32'd0;
      o_misalign  = 1'b0;
      case (i_func3)
         F3_B: begin
            o_we_mask   = 4'b0001 << i_addr;
            o_din       = {4{i_wdata[7:0]}};
            o_rdata_ext = {{24{w_byte[7]}}, w_byte};
         end
         F3_H: begin
            o_we_mask   = i_addr[1] ? 4'b1100 : 4'b0011;
            o_din       = {2{i_wdata[15:0]}};
            o_rdata_ext = {{16{w_half[15]}}, w_half};
            o_misalign  = i_addr[0];
         end
         F3_W: begin
            o_we_mask   = 4'b1111;
            o_din       = i_wdata;
            o_rdata_ext = i_rdata;
            o_misalign  = |i_addr;
         end
         F3_BU: begin
            o_rdata_ext = {24'd0, w_byte};
         end
         F3_HU: begin
            o_rdata_ext = {16'd0, w_half};
            o_misalign  = i_addr[0];
         end
         default: begin
            o_we_mask = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares one data-memory port between the scalar LSU (requester 0) and the
// PSRF load/store unit (requester 1). One transaction is in flight at a time:
// IDLE (round-robin grant) -> ISSUE (one memory cycle) -> WAIT (loads only,
// RD_LAT cycles) -> RESP (held until the owner takes it).
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req_valid/o_req_ready       per-requester request handshake
//   i_req_we/func3/addr/wdata     per-requester request fields
//   o_rsp_valid/i_rsp_ready       per-requester response handshake
//   o_rsp_rdata, o_rsp_err        shared response payload
//   o_mem_en/we/addr/din, i_mem_dout   data-memory port
// Parameters: AW word-address width, RD_LAT memory read latency (1..4).
// ----------------------------------------------------------------------------
module dmem_port_arbiter
   import dmem_pkg::*;
#(
   parameter int AW     = 12,
   parameter int RD_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_req_valid,
   output logic [1:0]        o_req_ready,
   input  logic [1:0]        i_req_we,
   input  logic [1:0][2:0]   i_req_func3,
   input  logic [1:0][31:0]  i_req_addr,
   input  logic [1:0][31:0]  i_req_wdata,
   output logic [1:0]        o_rsp_valid,
   input  logic [1:0]        i_rsp_ready,
   output logic [31:0]       o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_mem_en,
   output logic [3:0]        o_mem_we,
   output logic [AW-1:0]     o_mem_addr,
   output logic [31:0]       o_mem_din,
   input  logic [31:0]       i_mem_dout
);

   // The counter reaches 0 in the cycle the read data is valid.
   localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

   state_e          r_state;
   state_e          w_next;
   logic            r_last_grant;
   logic            r_grant;
   logic            r_we;
   logic [2:0]      r_func3;
   logic [AW+1:0]   r_addr;
   logic [31:0]     r_wdata;
   logic [1:0]      r_cnt;
   logic [31:0]     r_rsp_rdata;
   logic            r_rsp_err;

   logic            w_grant;
   logic            w_err;
   logic            w_misalign;
   logic [3:0]      w_we_mask;
   logic [31:0]     w_din;
   logic [31:0]     w_rdata_ext;
   logic            w_unused_addr;

   // Address bits above the memory window never reach the port.
   assign w_unused_addr = ^{i_req_addr[0][31:AW+2], i_req_addr[1][31:AW+2]};

   dmem_lane_align u_lane_align (
      .i_func3     (r_func3),
      .i_addr      (r_addr[1:0]),
      .i_wdata     (r_wdata),
      .i_rdata     (i_mem_dout),
      .o_we_mask   (w_we_mask),
      .o_din       (w_din),
      .o_rdata_ext (w_rdata_ext),
      .o_misalign  (w_misalign)
   );

   assign w_err       = f3_illegal(r_we, r_func3) | w_misalign;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err;

   // Round-robin grant: on contention the requester not served last wins.
   always_comb begin
      if (i_req_valid == 2'b11) begin
         w_grant = ~r_last_grant;
      end else if (i_req_valid[0]) begin
         w_grant = 1'b0;
      end else begin
         w_grant = 1'b1;
      end
   end

   // Next-state and memory/handshake outputs for the current state.
   always_comb begin
      w_next      = r_state;
      o_req_ready = 2'b00;
      o_rsp_valid = 2'b00;
      o_mem_en    = 1'b0;
      o_mem_we    = 4'b0000;
      o_mem_addr  = {AW{1'b0}};
      o_mem_din   = 32'd0;
      case (r_state)
         IDLE: begin
            if (|i_req_valid) begin
               o_req_ready[w_grant] = 1'b1;
               w_next               = ISSUE;
            end else begin
               w_next = IDLE;
            end
         end
         ISSUE: begin
            if (w_err) begin
               w_next = RESP;
            end else begin
               o_mem_en   = 1'b1;
               o_mem_addr = r_addr[AW+1:2];
               if (r_we) begin
                  o_mem_we  = w_we_mask;
                  o_mem_din = w_din;
                  w_next    = RESP;
               end else begin
                  w_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (r_cnt == 2'd0) begin
               w_next = RESP;
            end else begin
               w_next = WAIT;
            end
         end
         RESP: begin
            o_rsp_valid[r_grant] = 1'b1;
            if (i_rsp_ready[r_grant]) begin
               w_next = IDLE;
            end else begin
               w_next = RESP;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Request capture, read-latency counter and response payload.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_we         <= 1'b0;
         r_func3      <= 3'b000;
         r_addr       <= {(AW+2){1'b0}};
         r_wdata      <= 32'd0;
         r_cnt        <= 2'd0;
         r_rsp_rdata  <= 32'd0;
         r_rsp_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|i_req_valid) begin
                  r_grant      <= w_grant;
                  r_last_grant <= w_grant;
                  r_we         <= i_req_we[w_grant];
                  r_func3      <= i_req_func3[w_grant];
                  r_addr       <= i_req_addr[w_grant][AW+1:0];
                  r_wdata      <= i_req_wdata[w_grant];
                  // Stores and errors report zero data.
                  r_rsp_rdata  <= 32'd0;
                  r_rsp_err    <= 1'b0;
               end
            end
            ISSUE: begin
               if (w_err) begin
                  r_rsp_err <= 1'b1;
               end else if (!r_we) begin
                  r_cnt <= CNT_INIT;
               end
            end
            WAIT: begin
               if (r_cnt == 2'd0) begin
                  r_rsp_rdata <= w_rdata_ext;
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter. Expected responses are queued when a
// request handshake is seen and popped when the DUT raises rsp_valid.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 time
// units after it.
// ----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

   localparam int AW     = 12;
   localparam int RD_LAT = 1;
   localparam logic [31:0] MEM_WORD = 32'h80FF7F01;
   localparam logic [31:0] MEM_IDLE = 32'h13579BDF;

   typedef struct packed {
      logic        owner;
      logic [31:0] rdata;
      logic        err;
      logic [7:0]  lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_we;
   logic [1:0][2:0]  req_func3;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [31:0]      rsp_rdata;
   logic             rsp_err;
   logic             mem_en;
   logic [3:0]       mem_we;
   logic [AW-1:0]    mem_addr;
   logic [31:0]      mem_din;
   logic [31:0]      mem_dout;
   logic             en_d = 1'b0;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   dmem_port_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_we    (req_we),
      .i_req_func3 (req_func3),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_rdata (rsp_rdata),
      .o_rsp_err   (rsp_err),
      .o_mem_en    (mem_en),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_din   (mem_din),
      .i_mem_dout  (mem_dout)
   );

   always #5 clk = ~clk;

   // Memory model with a one-cycle read latency: the data word is only
   // presented in the cycle after mem_en, other cycles carry a decoy.
   always @(posedge clk) en_d <= mem_en;
   assign mem_dout = en_d ? MEM_WORD : MEM_IDLE;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
      check({tag, "_mem_en"},    32'(mem_en), 32'd0);
      check({tag, "_mem_we"},    32'(mem_we), 32'd0);
      check({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
      check({tag, "_mem_din"},   mem_din, 32'd0);
   endtask

   // Pop the oldest expected response and compare it with the DUT outputs.
   task automatic check_rsp(input int obs_lat);
      exp_t       e;
      logic [1:0] v_owner;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e       = sb.pop_front();
         v_owner = 2'b01 << e.owner;
         check("rsp_owner", 32'(rsp_valid), 32'(v_owner));
         check("rsp_rdata", rsp_rdata, e.rdata);
         check("rsp_err",   32'(rsp_err), 32'(e.err));
         check("rsp_lat",   32'(obs_lat), 32'(e.lat));
         check("rsp_mem_en_low", 32'(mem_en), 32'd0);
         check("rsp_mem_we_low", 32'(mem_we), 32'd0);
      end
   endtask

   // One complete transaction for requester r; called at edge+1, returns at edge+1.
   task automatic do_req(input int r, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [3:0] exp_we, input logic [31:0] exp_din);
      int          n;
      int          lat;
      logic [31:0] v_addr;
      v_addr       = addr;
      req_valid[r] = 1'b1;
      req_we[r]    = we;
      req_func3[r] = f3;
      req_addr[r]  = addr;
      req_wdata[r] = wdata;
      #1;
      n = 0;
      while (!req_ready[r] && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      check("req_handshake", 32'(req_ready[r]), 32'd1);
      sb.push_back('{owner: r[0], rdata: exp_rdata, err: exp_err,
                     lat: ((exp_err || we) ? 8'd2 : 8'(2 + RD_LAT))});
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
      #1;
      check("issue_mem_en", 32'(mem_en), exp_err ? 32'd0 : 32'd1);
      check("issue_mem_we", 32'(mem_we), 32'(exp_we));
      if (!exp_err) begin
         check("issue_mem_addr", 32'(mem_addr), 32'(v_addr[13:2]));
      end
      if (we && !exp_err) begin
         check("issue_mem_din", mem_din, exp_din);
      end
      lat = 1;
      while (!rsp_valid[r] && lat < 20) begin
         @(posedge clk); #2;
         lat++;
      end
      check_rsp(lat);
      @(posedge clk); #1;
   endtask

   initial begin
      int   gcount;
      int   gcyc;
      int   lat;
      logic g;
      logic seen;

      rst       = 1'b1;
      req_valid = 2'b00;
      req_we    = 2'b00;
      req_func3 = '{3'b000, 3'b000};
      req_addr  = '{32'd0, 32'd0};
      req_wdata = '{32'd0, 32'd0};
      rsp_ready = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;

      // Stores: word, byte, half lanes.
      do_req(0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 1'b0, 4'b1111, 32'hDEADBEEF);
      do_req(1, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'd0, 1'b0, 4'b1000, 32'hA5A5A5A5);
      do_req(1, 1'b1, 3'b001, 32'h202, 32'h00001234, 32'd0, 1'b0, 4'b1100, 32'h12341234);
      do_req(0, 1'b1, 3'b000, 32'h200, 32'h0000005C, 32'd0, 1'b0, 4'b0001, 32'h5C5C5C5C);
      do_req(0, 1'b1, 3'b001, 32'h200, 32'h0000BEEF, 32'd0, 1'b0, 4'b0011, 32'hBEEFBEEF);

      // Loads against mem word 0x80FF7F01.
      do_req(0, 1'b0, 3'b000, 32'h003, 32'd0, 32'hFFFFFF80, 1'b0, 4'b0000, 32'd0);
      do_req(0, 1'b0, 3'b100, 32'h003, 32'd0, 32'h00000080, 1'b0, 4'b0000, 32'd0);
      do_req(1, 1'b0, 3'b001, 32'h000, 32'd0, 32'h00007F01, 1'b0, 4'b0000, 32'd0);
      do_req(1, 1'b0, 3'b101, 32'h002, 32'd0, 32'h000080FF, 1'b0, 4'b0000, 32'd0);
      do_req(0, 1'b0, 3'b010, 32'h004, 32'd0, 32'h80FF7F01, 1'b0, 4'b0000, 32'd0);
      do_req(0, 1'b0, 3'b000, 32'h001, 32'd0, 32'h0000007F, 1'b0, 4'b0000, 32'd0);
      do_req(1, 1'b0, 3'b001, 32'h002, 32'd0, 32'hFFFF80FF, 1'b0, 4'b0000, 32'd0);

      // Errors: misaligned word/half, illegal funct3.
      do_req(0, 1'b1, 3'b010, 32'h102, 32'h11111111, 32'd0, 1'b1, 4'b0000, 32'd0);
      do_req(1, 1'b0, 3'b001, 32'h001, 32'd0, 32'd0, 1'b1, 4'b0000, 32'd0);
      do_req(0, 1'b1, 3'b011, 32'h000, 32'h22222222, 32'd0, 1'b1, 4'b0000, 32'd0);
      do_req(1, 1'b1, 3'b100, 32'h000, 32'h33333333, 32'd0, 1'b1, 4'b0000, 32'd0);

      // Round-robin with both requesters valid; fresh reset so last_grant = 1.
      rst = 1'b1;
      @(posedge clk); #1;
      rst          = 1'b0;
      req_we       = 2'b11;
      req_func3[0] = 3'b010;
      req_func3[1] = 3'b010;
      req_addr[0]  = 32'h010;
      req_addr[1]  = 32'h020;
      req_wdata[0] = 32'hAAAA0000;
      req_wdata[1] = 32'h0000BBBB;
      req_valid    = 2'b11;
      #1;
      gcount = 0;
      gcyc   = 0;
      for (int i = 0; i < 12; i++) begin
         check("rr_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
         if (|req_ready) begin
            g = req_ready[1];
            check("rr_grant_order", 32'(g), 32'(gcount % 2));
            sb.push_back('{owner: g, rdata: 32'd0, err: 1'b0, lat: 8'd2});
            gcyc = i;
            gcount++;
         end
         if (|rsp_valid) begin
            check_rsp(i - gcyc);
         end
         @(posedge clk); #2;
      end
      req_valid = 2'b00;
      check("rr_grant_count", 32'(gcount), 32'd4);
      @(posedge clk); #1;

      // Reset during WAIT of a load drops it.
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_func3[0] = 3'b010;
      req_addr[0]  = 32'h000;
      #1;
      check("drop_handshake", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      #1;
      check("drop_issue_en", 32'(mem_en), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs("mid_reset");
      rst  = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (rsp_valid != 2'b00) seen = 1'b1;
      end
      check("drop_no_rsp", 32'(seen), 32'd0);
      do_req(0, 1'b1, 3'b010, 32'h040, 32'h0BADF00D, 32'd0, 1'b0, 4'b1111, 32'h0BADF00D);

      // Response back-pressure: owner is requester 1, requester 0 waits.
      rsp_ready    = 2'b01;
      req_valid    = 2'b10;
      req_we[1]    = 1'b0;
      req_func3[1] = 3'b010;
      req_addr[1]  = 32'h000;
      #1;
      check("bp_handshake", 32'(req_ready), 32'd2);
      sb.push_back('{owner: 1'b1, rdata: 32'h80FF7F01, err: 1'b0, lat: 8'(2 + RD_LAT)});
      @(posedge clk); #1;
      req_valid    = 2'b01;
      req_we[0]    = 1'b1;
      req_func3[0] = 3'b010;
      req_addr[0]  = 32'h030;
      req_wdata[0] = 32'h11223344;
      #1;
      lat = 1;
      while (!rsp_valid[1] && lat < 20) begin
         @(posedge clk); #2;
         lat++;
      end
      check_rsp(lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         check("bp_rsp_valid", 32'(rsp_valid), 32'd2);
         check("bp_rsp_rdata", rsp_rdata, 32'h80FF7F01);
         check("bp_no_accept", 32'(req_ready), 32'd0);
      end
      rsp_ready = 2'b11;
      @(posedge clk); #2;
      check("bp_back_idle", 32'(req_ready), 32'd1);
      sb.push_back('{owner: 1'b0, rdata: 32'd0, err: 1'b0, lat: 8'd2});
      @(posedge clk); #1;
      req_valid = 2'b00;
      #1;
      check("bp_st_mem_we", 32'(mem_we), 32'hF);
      check("bp_st_mem_addr", 32'(mem_addr), 32'h00C);
      check("bp_st_mem_din", mem_din, 32'h11223344);
      lat = 1;
      while (!rsp_valid[0] && lat < 20) begin
         @(posedge clk); #2;
         lat++;
      end
      check_rsp(lat);
      @(posedge clk); #1;
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences and shares the single data-memory port between two requesters: requester 0 is the scalar LSU and requester 1 is the PSRF load/store unit.
- Per granted request it builds the 4-bit byte-lane write mask and lane-aligned write data, issues the memory cycle, waits the read latency for loads, and returns the sign- or zero-extended load data.
- Sits between the core's memory stage and the data memory.
- Replaces per-requester mask generation with one arbitrated, sequenced port.

Parameters:
- AW, 12, memory word-address width. mem_addr = addr[AW+1:2].
- RD_LAT, 1, data-memory read latency in cycles. Legal range is 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  request valid, one bit per requester.
- req_ready  out  2  request accepted. Handshake completes when valid and ready are both high.
- req_we  in  2  1 = store, 0 = load.
- req_func3  in  2x3  RV32 funct3 per requester. Stores: 000 SB, 001 SH, 010 SW. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- req_addr  in  2x32  byte address.
- req_wdata  in  2x32  store data, right-justified.
- rsp_valid  out  2  response valid for the owning requester.
- rsp_ready  in  2  response consumed.
- rsp_rdata  out  32  load result. Forced to 0 for stores and for errors.
- rsp_err  out  1  misaligned access or illegal funct3.
- mem_en  out  1  memory access enable.
- mem_we  out  4  byte-lane write mask.
- mem_addr  out  AW  word address.
- mem_din  out  32  lane-aligned write data.
- mem_dout  in  32  read data, valid RD_LAT cycles after the mem_en cycle.

Behaviour:
- Reset:
  - state = IDLE, last_grant = 1, wait counter = 0.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_din.
- Reset mid-operation drops the in-flight transaction; no response is produced for it.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = round-robin over req_valid. If only one requester is valid, it wins.
  - If both are valid, the requester other than last_grant wins.
  - req_ready[grant] = 1, combinational from req_valid, asserted only in IDLE.
  - On handshake: register we, func3, addr, wdata and grant; update last_grant; go to ISSUE.
  - No valid request: stay in IDLE.
- Error check, done on the registered request:
  - SH or LH/LHU with addr[0] = 1 is an error.
  - SW or LW with addr[1:0] != 0 is an error.
  - Any funct3 not listed in the port table is an error.
- ISSUE, error case: mem_en = 0, rsp_err = 1, go to RESP.
- ISSUE, legal case: mem_en = 1, mem_addr = addr[AW+1:2], for exactly one cycle.
  - Store masks: SW gives mem_we 1111. SH gives 1100 if addr[1] = 1, else 0011. SB gives the one-hot (1 << addr[1:0]).
  - mem_din = wdata replicated into lanes (byte x4, half x2, word as-is).
  - Load: mem_we = 0000, go to WAIT with counter = RD_LAT - 1.
  - Store: go to RESP.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, capture mem_dout. Select the byte by addr[1:0] or the half by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Go to RESP.
- RESP:
  - rsp_valid[grant] = 1; rsp_rdata and rsp_err are held stable.
  - Leave to IDLE when rsp_ready[grant] = 1. rsp_ready of the non-owning requester is ignored.
  - No new request is accepted until state returns to IDLE.
- Latency, handshake to rsp_valid:
  - Store: 2 cycles.
  - Load: 2 + RD_LAT cycles.
  - Error: 2 cycles.
- Minimum back-to-back store throughput is 1 per 3 cycles.
- mem_we is nonzero only in ISSUE for legal stores. A legal store never drives a mask with zero lanes set.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum typedef: IDLE, ISSUE, WAIT, RESP.
  - OPC_STORE = 7'h23 and OPC_PSRF_ST = 7'h24, used by the decode feeding this block.
- One sub-module, dmem_lane_align (combinational):
  - Inputs: func3, addr[1:0], wdata, rdata.
  - Outputs: mem_we mask, replicated din, extended load result, misalign flag.
  - Reused by both the store path and the load path.

Test Plan:
1. Reset released, req0 SW addr 0x100 wdata 0xDEADBEEF -> ISSUE cycle has mem_we 1111, mem_addr 0x40, mem_din 0xDEADBEEF; rsp_valid[0] 2 cycles after handshake; rsp_err 0.
2. req1 SB addr 0x203 wdata 0x000000A5 -> mem_we 1000, mem_din 0xA5A5A5A5. Then SH addr 0x202 wdata 0x1234 -> mem_we 1100, mem_din 0x12341234.
3. mem_dout = 0x80FF7F01, RD_LAT = 1:
   - LB addr 0x003 gives rsp_rdata 0xFFFFFF80.
   - LBU addr 0x003 gives 0x00000080.
   - LH addr 0x000 gives 0x00007F01.
   - LHU addr 0x002 gives 0x000080FF.
   - LW gives 0x80FF7F01.
   - rsp_valid arrives 3 cycles after each handshake.
4. Both requesters held valid continuously with rsp_ready = 1 -> grants alternate 0,1,0,1; req_ready is never high on both bits in one cycle.
5. SW addr 0x102 and LH addr 0x001 -> mem_en stays 0, rsp_err = 1, rsp_rdata = 0, mem_we = 0. funct3 = 011 store -> rsp_err = 1.
6. rst asserted during WAIT of a load -> next cycle all outputs are 0 and state is IDLE; no rsp_valid is ever produced for the dropped load. rsp_ready held low in RESP for 5 cycles -> rsp_valid and rsp_rdata stay stable and no new request is accepted.
